// File: rtl/riscnet_pipe_pkg.sv
// Shared pipeline types: default ID->IE field widths and the packed
// entry bundle {opcode, mode, op1, op2} carried between the two stages.
package riscnet_pipe_pkg;

    localparam int OPC_W_DEF  = 8;
    localparam int MODE_W_DEF = 2;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic [OPC_W_DEF-1:0]  opcode;
        logic [MODE_W_DEF-1:0] mode;
        logic [DATA_W_DEF-1:0] op1;
        logic [DATA_W_DEF-1:0] op2;
    } id_ie_entry_t;

    localparam int ID_IE_ENTRY_W = $bits(id_ie_entry_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/in_data
// upstream; out_valid/out_ready/out_data downstream. in_ready is a flop.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         rdy_q, rdy_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;

    logic accept;
    logic issue;
    logic main_free;

    assign accept    = in_valid & rdy_q;
    assign issue     = main_vld_q & out_ready;
    assign main_free = ~main_vld_q | issue;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
            // Payloads are left stale; only the valid bits matter.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (main_free) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
                if (accept) begin
                    skid_d     = in_data;
                    skid_vld_d = 1'b1;
                end
            end else if (accept) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_data;
            skid_vld_d = 1'b1;
        end
        // Ready depends only on next-state occupancy, never on out_ready
        // combinationally at the output.
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

endmodule

// File: rtl/id_ie_stage_reg.sv
// ID->IE pipeline register: skid-buffered entry transfer with flush and
// a saturating downstream-stall counter. Ports: clk, rst_n, flush,
// in_valid/in_ready + opcode/mode/op1/op2 in, out_valid/out_ready +
// opcode/mode/op1/op2 out, stall_cnt.
module id_ie_stage_reg
    import riscnet_pipe_pkg::*;
#(
    parameter int OPC_W  = OPC_W_DEF,
    parameter int MODE_W = MODE_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode_in,
    input  logic [MODE_W-1:0] mode_in,
    input  logic [DATA_W-1:0] op1_in,
    input  logic [DATA_W-1:0] op2_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  opcode_out,
    output logic [MODE_W-1:0] mode_out,
    output logic [DATA_W-1:0] op1_out,
    output logic [DATA_W-1:0] op2_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Same layout as id_ie_entry_t, but sized by this instance's widths.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } entry_t;

    entry_t in_e;
    entry_t out_e;
    logic   out_vld;

    assign in_e.opcode = opcode_in;
    assign in_e.mode   = mode_in;
    assign in_e.op1    = op1_in;
    assign in_e.op2    = op2_in;

    pipe_skid_buf #(
        .W($bits(entry_t))
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_e),
        .out_valid(out_vld),
        .out_ready(out_ready),
        .out_data (out_e)
    );

    assign out_valid  = out_vld;
    assign opcode_out = out_e.opcode;
    assign mode_out   = out_e.mode;
    assign op1_out    = out_e.op1;
    assign op2_out    = out_e.op2;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Flush does not touch the counter; it is a pure perf monitor.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_vld && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ie_stage_reg.sv
// Self-checking bench for id_ie_stage_reg: directed table, saturation,
// randomized scoreboard run and asynchronous mid-stall reset.
module tb_id_ie_stage_reg;
    import riscnet_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode_in;
    logic [1:0]  mode_in;
    logic [15:0] op1_in;
    logic [15:0] op2_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  opcode_out;
    logic [1:0]  mode_out;
    logic [15:0] op1_out;
    logic [15:0] op2_out;
    logic [15:0] stall_cnt;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_opcode_out;
    logic [1:0]  s_mode_out;
    logic [15:0] s_op1_out;
    logic [15:0] s_op2_out;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    id_ie_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .mode_in(mode_in),
        .op1_in(op1_in), .op2_in(op2_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode_out(opcode_out), .mode_out(mode_out),
        .op1_out(op1_out), .op2_out(op2_out),
        .stall_cnt(stall_cnt)
    );

    id_ie_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .opcode_in(8'h77), .mode_in(2'd1),
        .op1_in(16'h1234), .op2_in(16'h5678),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .opcode_out(s_opcode_out), .mode_out(s_mode_out),
        .op1_out(s_op1_out), .op2_out(s_op2_out),
        .stall_cnt(s_stall_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        bit         iv;
        bit         ordy;
        bit         fl;
        logic [7:0] opc;
        bit         ev;
        bit         er;
        logic [7:0] eopc;
        int         est;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit iv, bit ordy, bit fl, logic [7:0] opc,
                                bit ev, bit er, logic [7:0] eopc, int est);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.opc = opc;
        v.ev = ev; v.er = er; v.eopc = eopc; v.est = est;
        return v;
    endfunction

    function automatic id_ie_entry_t tbl_entry(logic [7:0] opc);
        id_ie_entry_t e;
        e.opcode = opc;
        e.mode   = opc[1:0];
        e.op1    = 16'h1000 + {8'h00, opc};
        e.op2    = {opc, 8'hA5};
        return e;
    endfunction

    task automatic drive(input bit iv, input bit ordy, input bit fl,
                         input id_ie_entry_t e);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        opcode_in = e.opcode;
        mode_in   = e.mode;
        op1_in    = e.op1;
        op2_in    = e.op2;
    endtask

    // Reference model: a FIFO of at most two entries.
    id_ie_entry_t mq[$];
    int           mstall;
    id_ie_entry_t cur;

    task automatic model_edge();
        int sz;
        sz = mq.size();
        if (sz > 0 && !out_ready && mstall < 65535) mstall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) mq.push_back(cur);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mstall));
        if (mq.size() > 0) begin
            chk({tag, ".payload"},
                32'({opcode_out, mode_out, op1_out, op2_out} != mq[0]),
                32'd0);
        end
    endtask

    initial begin
        id_ie_entry_t e;
        rst_n = 1'b0;
        s_flush = 1'b0;
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.opcode", 32'(opcode_out), 32'd0);
        chk("rst.op1", 32'(op1_out), 32'd0);
        chk("rst.stall", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;

        tbl[0]  = mk(1, 1, 0, 8'h01, 1, 1, 8'h01, 0);
        tbl[1]  = mk(1, 1, 0, 8'h02, 1, 1, 8'h02, 0);
        tbl[2]  = mk(1, 1, 0, 8'h03, 1, 1, 8'h03, 0);
        tbl[3]  = mk(1, 1, 0, 8'h04, 1, 1, 8'h04, 0);
        tbl[4]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 0);
        tbl[5]  = mk(1, 0, 0, 8'h11, 1, 1, 8'h11, 0);
        tbl[6]  = mk(1, 0, 0, 8'h12, 1, 0, 8'h11, 1);
        tbl[7]  = mk(1, 0, 0, 8'h13, 1, 0, 8'h11, 2);
        tbl[8]  = mk(1, 0, 0, 8'h13, 1, 0, 8'h11, 3);
        tbl[9]  = mk(1, 1, 0, 8'h13, 1, 1, 8'h12, 3);
        tbl[10] = mk(1, 1, 0, 8'h13, 1, 1, 8'h13, 3);
        tbl[11] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 3);
        tbl[12] = mk(1, 0, 0, 8'h21, 1, 1, 8'h21, 3);
        tbl[13] = mk(1, 0, 0, 8'h22, 1, 0, 8'h21, 4);
        tbl[14] = mk(1, 0, 1, 8'h55, 0, 1, 8'h00, 5);
        tbl[15] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 5);
        tbl[16] = mk(1, 1, 1, 8'h66, 0, 1, 8'h00, 5);
        tbl[17] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 5);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl_entry(tbl[i].opc));
            @(negedge clk);
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid),
                32'(tbl[i].ev));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready),
                32'(tbl[i].er));
            chk($sformatf("vec%0d.stall", i), 32'(stall_cnt),
                32'(tbl[i].est));
            if (tbl[i].ev) begin
                e = tbl_entry(tbl[i].eopc);
                chk($sformatf("vec%0d.entry", i),
                    32'({opcode_out, mode_out, op1_out, op2_out} != e),
                    32'd0);
            end
        end

        // Saturation on the 4-bit counter instance.
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("sat.start", 32'(s_stall_cnt), 32'd0);
        repeat (15) @(negedge clk);
        chk("sat.at15", 32'(s_stall_cnt), 32'd15);
        repeat (5) @(negedge clk);
        chk("sat.hold", 32'(s_stall_cnt), 32'd15);
        chk("sat.out_valid", 32'(s_out_valid), 32'd1);
        chk("sat.opcode", 32'(s_opcode_out), 32'h77);

        // Randomized run against the FIFO model.
        mstall = 5;
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            cur.opcode = 8'($urandom);
            cur.mode   = 2'($urandom);
            cur.op1    = 16'($urandom);
            cur.op2    = 16'($urandom);
            // in_ready must not react to out_ready within the cycle.
            out_ready = 1'b0;
            #1;
            chk("rnd.rdy_or0", 32'(in_ready), 32'(mq.size() < 2));
            out_ready = 1'b1;
            #1;
            chk("rnd.rdy_or1", 32'(in_ready), 32'(mq.size() < 2));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, cur);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk_model("rnd");
        end

        // Async reset asserted between edges while stalled.
        drive(1'b1, 1'b0, 1'b0, tbl_entry(8'h99));
        repeat (3) @(negedge clk);
        chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.payload",
            32'({opcode_out, mode_out, op1_out, op2_out} != '0), 32'd0);
        chk("arst.stall", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ie_stage_reg.md
# id_ie_stage_reg

Parametrised ID→IE pipeline register with a valid/ready handshake on both sides. It carries the opcode, addressing mode and two operands from decode to execute. A two-entry skid buffer sustains one transfer per cycle while keeping `in_ready` a pure register output. It supports a synchronous flush for branch/exception squash and counts downstream stall cycles for performance monitoring.

## Interface
- `OPC_W`, 8, opcode width
- `MODE_W`, 2, addressing-mode width
- `DATA_W`, 16, width of each operand
- `CNT_W`, 16, stall-counter width
- `clk` in 1: single clock; all state updates on the rising edge only.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: decode presents an entry.
- `in_ready` out 1: stage can accept an entry (registered).
- `opcode_in` in OPC_W: decoded opcode.
- `mode_in` in MODE_W: addressing mode.
- `op1_in`, `op2_in` in DATA_W: operands.
- `out_valid` out 1: entry presented to execute.
- `out_ready` in 1: execute accepts the entry.
- `opcode_out` out OPC_W; `mode_out` out MODE_W; `op1_out`, `op2_out` out DATA_W.
- `stall_cnt` out CNT_W: saturating count of downstream-stall cycles.

## Operation
- Two entries: main (drives the outputs) and skid. Each entry is a payload plus a valid bit.
- Accept = `in_valid & in_ready`; issue = `out_valid & out_ready`.
- Main is free this cycle if it is empty or it issues.
- Main free, skid valid:
  - main loads the skid entry and skid clears;
  - if accept also occurs, the input entry goes to skid.
- Main free, skid empty: main loads the input on accept; otherwise `out_valid` drops.
- Main not free and accept occurs: the input goes to skid.
- `in_ready` next = skid empty after the update. It is never combinationally dependent on `out_ready`.
- Ordering is strictly FIFO; no entry is dropped or duplicated except on flush.
- `flush` takes priority over everything:
  - next cycle, `out_valid`=0, skid empty, `in_ready`=1;
  - any input offered in the flush cycle is discarded, even if `in_ready` was high;
  - payload registers may hold stale values.
- Payload registers load only when their entry is filled; they hold otherwise.
- `stall_cnt` increments each cycle that `out_valid & ~out_ready` holds. It saturates at all-ones and is unaffected by flush.

## Timing
- Reset (async assert): `out_valid`=0, skid valid=0, `in_ready`=1, all payload outputs 0, `stall_cnt`=0.
- Reset takes effect immediately, including mid-transfer; deassertion is synchronised externally.
- Latency: an entry accepted at edge N appears on the outputs after edge N (visible in cycle N+1) when main is free.
- Throughput: one entry per cycle with `out_ready` held high.
- Backpressure: after `out_ready` falls with a valid output, at most one further entry is accepted (into skid); `in_ready` is low from the next cycle.
- Outputs stay stable while `out_valid & ~out_ready`.

## Structure
- Shared package `riscnet_pipe_pkg` holds the default widths and a packed `id_ie_entry_t` struct {opcode, mode, op1, op2}.
- One natural sub-module, `pipe_skid_buf`: a generic two-entry valid/ready skid buffer parametrised on payload width. `id_ie_stage_reg` instantiates it with the packed entry and adds flush and the stall counter.

## Test plan
- Reset, then stream 4 entries (opcode 0x01..0x04, op1 = 0x1000+i) with `out_ready`=1 → each appears one cycle after accept, in order, `in_ready` stays 1, `stall_cnt`=0.
- Hold `out_ready`=0 while sending 0x11, 0x12, 0x13 → 0x11 on outputs, 0x12 in skid, `in_ready`=0, 0x13 not accepted. Raise `out_ready` → 0x11, 0x12, 0x13 issue in order; `stall_cnt` = cycles held low.
- Full buffer, pulse `flush` with `in_valid`=1 (opcode 0x55) → next cycle `out_valid`=0, `in_ready`=1, 0x55 never issues.
- Random `in_valid`/`out_ready` for 10k cycles against a scoreboard → no loss, duplication or reordering; `in_ready` is a function of registered state only.
- CNT_W=4, stall 20 cycles → `stall_cnt` saturates at 15.
- Assert `rst_n` low mid-stall, between edges → outputs go to reset values immediately, before the next clock edge.
